// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes,
// sequencer states and small decode helpers.
package ctrl_pkg;

  localparam logic [3:0] OP_LDB  = 4'b1000;
  localparam logic [3:0] OP_STB  = 4'b1001;
  localparam logic [3:0] OP_LDH  = 4'b1010;
  localparam logic [3:0] OP_LDL  = 4'b1011;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // The nibble-merge loads only work when each half of the data word is
  // exactly as wide as the immediate field IR[IW-5:1].
  function automatic bit widthsConsistent(int iw, int dw);
    return dw == 2 * (iw - 5);
  endfunction

  // Anything that is not one of the named opcodes is an ALU (r-type) op.
  function automatic bit isRType(logic [3:0] op);
    return !(op inside {OP_LDB, OP_STB, OP_LDH, OP_LDL, OP_MOV, OP_JMP, OP_HALT});
  endfunction

endpackage

// File: rtl/ctrl_wb_mux.sv
// Write-back value selector: picks the register write data for the
// instruction held in IR. Qualification by the write enable is done by
// the sequencer.
module ctrl_wb_mux
  import ctrl_pkg::*;
#(
  parameter int IW = 9,
  parameter int DW = 8
) (
  input  logic [3:0]    i_op,
  input  logic [IW-5:0] i_operand,
  input  logic [DW-1:0] i_rdValue,
  input  logic [DW-1:0] i_aluOut,
  input  logic [DW-1:0] i_memReadValue,
  output logic [DW-1:0] o_value
);

  // Select the data source by opcode; immediates are zero-extended, never sign-extended.
  always_comb begin
    o_value = '0;
    case (i_op)
      OP_LDB:                  o_value = i_memReadValue;
      OP_MOV:                  o_value[IW-5:0] = i_operand;
      OP_LDH:                  o_value = {i_operand[IW-5:1], i_rdValue[DW/2-1:0]};
      OP_LDL:                  o_value = {i_rdValue[DW-1:DW/2], i_operand[IW-5:1]};
      OP_STB, OP_JMP, OP_HALT: o_value = '0;
      default:                 o_value = i_aluOut;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/execute/memory sequencer. Owns PC advance, branch
// resolution, register write-back, the memory handshake with timeout and
// the sticky overflow / memory-error status flags.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int IW      = 9,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [IW-1:0] Instruction,
  input  logic [DW-1:0] jmpReg,
  input  logic [DW-1:0] RdValue,
  input  logic [DW-1:0] ALU_out,
  input  logic          OverFlow,
  input  logic [DW-1:0] MemReadValue,
  input  logic          MemAck,
  output logic          MemReq,
  output logic          MemWe,
  output logic          PcEn,
  output logic          Jump,
  output logic          BranchEn,
  output logic          RegWriteEn,
  output logic [DW-1:0] RegWriteValue,
  output logic          Halted,
  output logic          OvfFlag,
  output logic          MemErr
);

  if (!widthsConsistent(IW, DW)) begin : g_badWidth
    $error("ctrl_seq: DW must equal 2*(IW-5)");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_badTimeout
    $error("ctrl_seq: TIMEOUT must be in 1..255");
  end

  state_t        r_state;
  state_t        w_nextState;
  logic [IW-1:0] r_ir;
  logic [7:0]    r_waitCnt;
  logic          r_memReq;
  logic          r_memWe;
  logic          r_ovf;
  logic          r_memErr;

  logic [3:0]    w_op;
  logic [IW-5:0] w_operand;
  logic [DW-1:0] w_wbValue;
  logic          w_startMem;
  logic          w_endMem;
  logic          w_timeout;
  logic          w_setOvf;

  assign w_op      = r_ir[IW-1:IW-4];
  assign w_operand = r_ir[IW-5:0];

  ctrl_wb_mux #(
    .IW(IW),
    .DW(DW)
  ) u_wbMux (
    .i_op          (w_op),
    .i_operand     (w_operand),
    .i_rdValue     (RdValue),
    .i_aluOut      (ALU_out),
    .i_memReadValue(MemReadValue),
    .o_value       (w_wbValue)
  );

  // Next-state and per-cycle control pulses; everything idles at 0 unless a case raises it.
  always_comb begin
    w_nextState = r_state;
    PcEn        = 1'b0;
    Jump        = 1'b0;
    BranchEn    = 1'b0;
    RegWriteEn  = 1'b0;
    w_startMem  = 1'b0;
    w_endMem    = 1'b0;
    w_timeout   = 1'b0;
    w_setOvf    = 1'b0;
    case (r_state)
      S_FETCH: w_nextState = S_EXEC;
      S_EXEC: begin
        case (w_op)
          OP_LDB, OP_STB: begin
            w_startMem  = 1'b1;
            w_nextState = S_MEM;
          end
          OP_HALT: w_nextState = S_HALT;
          OP_JMP: begin
            Jump        = 1'b1;
            BranchEn    = (jmpReg == DW'(1));
            PcEn        = 1'b1;
            w_nextState = S_FETCH;
          end
          default: begin
            RegWriteEn  = 1'b1;
            PcEn        = 1'b1;
            w_setOvf    = isRType(w_op) && OverFlow;
            w_nextState = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (MemAck) begin
          w_endMem    = 1'b1;
          PcEn        = 1'b1;
          RegWriteEn  = (w_op == OP_LDB);
          w_nextState = S_FETCH;
        end else if (r_waitCnt == 8'(TIMEOUT)) begin
          w_endMem    = 1'b1;
          w_timeout   = 1'b1;
          w_nextState = S_HALT;
        end
      end
      S_HALT:  w_nextState = S_HALT;
      default: w_nextState = S_FETCH;
    endcase
  end

  assign RegWriteValue = RegWriteEn ? w_wbValue : '0;
  assign Halted        = (r_state == S_HALT);
  assign MemReq        = r_memReq;
  assign MemWe         = r_memWe;
  assign OvfFlag       = r_ovf;
  assign MemErr        = r_memErr;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_FETCH;
    else          r_state <= w_nextState;
  end

  // Instruction register, captured only while fetching.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                r_ir <= '0;
    else if (r_state == S_FETCH) r_ir <= Instruction;
  end

  // Memory request/direction and the wait counter that restarts on every entry to S_MEM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_memReq  <= 1'b0;
      r_memWe   <= 1'b0;
      r_waitCnt <= '0;
    end else if (w_startMem) begin
      r_memReq  <= 1'b1;
      r_memWe   <= (w_op == OP_STB);
      r_waitCnt <= '0;
    end else if (w_endMem) begin
      r_memReq  <= 1'b0;
      r_memWe   <= 1'b0;
    end else if (r_state == S_MEM) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end
  end

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ovf    <= 1'b0;
      r_memErr <= 1'b0;
    end else begin
      if (w_setOvf)  r_ovf    <= 1'b1;
      if (w_timeout) r_memErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed vector table, hand-written
// memory/reset corner cases, then random instructions checked against a
// behavioural model of the instruction set.
module tb_ctrl_seq;

  localparam int TIMEOUT_C = 15;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [8:0] Instruction = '0;
  logic [7:0] jmpReg = '0;
  logic [7:0] RdValue = '0;
  logic [7:0] ALU_out = '0;
  logic       OverFlow = 1'b0;
  logic [7:0] MemReadValue = '0;
  logic       MemAck = 1'b0;
  logic       MemReq, MemWe, PcEn, Jump, BranchEn, RegWriteEn, Halted, OvfFlag, MemErr;
  logic [7:0] RegWriteValue;

  int vectorsApplied = 0;
  int miscompares = 0;

  logic expOvf = 1'b0;
  logic expMemErr = 1'b0;
  logic expHalted = 1'b0;

  typedef struct packed {
    logic       memReq;
    logic       memWe;
    logic       pcEn;
    logic       jump;
    logic       branchEn;
    logic       regWriteEn;
    logic [7:0] regWriteValue;
    logic       halted;
    logic       ovfFlag;
    logic       memErr;
  } outs_t;

  typedef struct {
    string      tag;
    logic [8:0] instr;
    logic [7:0] jmp;
    logic [7:0] rd;
    logic [7:0] alu;
    logic       ovf;
    logic [7:0] expVal;
    logic       expBr;
  } vec_t;

  ctrl_seq #(.IW(9), .DW(8), .TIMEOUT(TIMEOUT_C)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Instruction  (Instruction),
    .jmpReg       (jmpReg),
    .RdValue      (RdValue),
    .ALU_out      (ALU_out),
    .OverFlow     (OverFlow),
    .MemReadValue (MemReadValue),
    .MemAck       (MemAck),
    .MemReq       (MemReq),
    .MemWe        (MemWe),
    .PcEn         (PcEn),
    .Jump         (Jump),
    .BranchEn     (BranchEn),
    .RegWriteEn   (RegWriteEn),
    .RegWriteValue(RegWriteValue),
    .Halted       (Halted),
    .OvfFlag      (OvfFlag),
    .MemErr       (MemErr)
  );

  always #5 Clk = ~Clk;

  function automatic outs_t mkExp(logic req, logic we, logic pc, logic jmp, logic br,
                                  logic rwe, logic [7:0] val);
    outs_t e;
    e = '{req, we, pc, jmp, br, rwe, val, expHalted, expOvf, expMemErr};
    return e;
  endfunction

  // Reference write-back value computed from the instruction-set rules.
  function automatic logic [7:0] refWb(logic [8:0] instr, logic [7:0] rd, logic [7:0] alu,
                                       logic [7:0] mem);
    int op, operand, imm4, r;
    op      = int'(instr) / 32;
    operand = int'(instr) % 32;
    imm4    = operand / 2;
    case (op)
      8:         r = int'(mem);
      7:         r = operand;
      10:        r = imm4 * 16 + int'(rd) % 16;
      11:        r = (int'(rd) / 16) * 16 + imm4;
      9, 12, 15: r = 0;
      default:   r = int'(alu);
    endcase
    return 8'(r);
  endfunction

  task automatic checkOutput(input string name, input outs_t expv);
    outs_t act;
    act = '{MemReq, MemWe, PcEn, Jump, BranchEn, RegWriteEn, RegWriteValue, Halted, OvfFlag, MemErr};
    vectorsApplied++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (req,we,pc,jmp,br,rwe,val[8],halt,ovf,merr)",
               name, act, expv);
    end
  endtask

  // Called in the FETCH cycle just after a falling edge; returns in the next
  // FETCH cycle (or in S_HALT after halt/timeout).
  task automatic applyStimulus(input string tag, input logic [8:0] instr, input logic [7:0] jmp,
                               input logic [7:0] rd, input logic [7:0] alu, input logic ovf,
                               input logic [7:0] memData, input int ackAt,
                               input logic [7:0] expVal, input logic expBr);
    int  op;
    bit  acked;
    bit  isMem;
    bit  isStb;
    op    = int'(instr) / 32;
    isMem = (op == 8) || (op == 9);
    isStb = (op == 9);
    Instruction = instr;
    jmpReg = jmp;
    RdValue = rd;
    ALU_out = alu;
    OverFlow = ovf;
    MemReadValue = memData;
    MemAck = 1'b0;
    #1 checkOutput({tag, "_fetch"}, mkExp(0, 0, 0, 0, 0, 0, 8'h00));
    @(negedge Clk);
    #1;
    if (isMem || op == 15)  checkOutput({tag, "_exec"}, mkExp(0, 0, 0, 0, 0, 0, 8'h00));
    else if (op == 12)      checkOutput({tag, "_exec"}, mkExp(0, 0, 1, 1, expBr, 0, 8'h00));
    else                    checkOutput({tag, "_exec"}, mkExp(0, 0, 1, 0, 0, 1, expVal));
    if (!isMem && op != 15 && op != 12 && op != 7 && op != 10 && op != 11 && ovf) expOvf = 1'b1;
    if (op == 15) begin
      expHalted = 1'b1;
      @(negedge Clk);
      #1 checkOutput({tag, "_halt"}, mkExp(0, 0, 0, 0, 0, 0, 8'h00));
      MemAck = 1'b1;
      @(negedge Clk);
      #1 checkOutput({tag, "_haltAckIgnored"}, mkExp(0, 0, 0, 0, 0, 0, 8'h00));
      MemAck = 1'b0;
      return;
    end
    if (isMem) begin
      acked = 0;
      for (int c = 1; c <= TIMEOUT_C + 1; c++) begin
        @(negedge Clk);
        MemAck = (c == ackAt);
        #1;
        if (c == ackAt) begin
          checkOutput({tag, "_ack"}, mkExp(1, isStb, 1, 0, 0, !isStb, isStb ? 8'h00 : expVal));
          acked = 1;
          break;
        end
        checkOutput({tag, "_wait"}, mkExp(1, isStb, 0, 0, 0, 0, 8'h00));
      end
      if (!acked) begin
        expMemErr = 1'b1;
        expHalted = 1'b1;
        @(negedge Clk);
        #1 checkOutput({tag, "_timeoutHalt"}, mkExp(0, 0, 0, 0, 0, 0, 8'h00));
        MemAck = 1'b1;
        @(negedge Clk);
        #1 checkOutput({tag, "_haltStays"}, mkExp(0, 0, 0, 0, 0, 0, 8'h00));
        MemAck = 1'b0;
        return;
      end
    end
    @(negedge Clk);
    MemAck = 1'b0;
  endtask

  // Asserts reset for a cycle, checks the all-zero reset outputs, releases it
  // in a FETCH cycle so the next rising edge performs the first fetch.
  task automatic applyReset(input string tag);
    Reset_n = 1'b0;
    MemAck = 1'b0;
    expOvf = 1'b0;
    expMemErr = 1'b0;
    expHalted = 1'b0;
    @(negedge Clk);
    #1 checkOutput(tag, mkExp(0, 0, 0, 0, 0, 0, 8'h00));
    Reset_n = 1'b1;
  endtask

  vec_t vecs[9];

  initial begin
    logic [8:0] rInstr;
    logic [7:0] rJmp, rRd, rAlu, rMem;
    logic       rOvf;
    int         rAck, sel;

    vecs[0] = '{"movImm",      9'h0F3, 8'h00, 8'h00, 8'h00, 1'b0, 8'h13, 1'b0};
    vecs[1] = '{"ldhImm",      9'h154, 8'h00, 8'h35, 8'h00, 1'b0, 8'hA5, 1'b0};
    vecs[2] = '{"ldlImm",      9'h178, 8'h00, 8'hA5, 8'h00, 1'b0, 8'hAC, 1'b0};
    vecs[3] = '{"jmpTaken",    9'h180, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{"jmpNotTaken", 9'h180, 8'h81, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{"jmpZero",     9'h180, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{"rtypeAdd",    9'h02A, 8'h00, 8'h00, 8'h77, 1'b0, 8'h77, 1'b0};
    vecs[7] = '{"movOvfIgn",   9'h0E5, 8'h00, 8'h00, 8'h00, 1'b1, 8'h05, 1'b0};
    vecs[8] = '{"rtypeOvf",    9'h0C1, 8'h00, 8'h00, 8'h80, 1'b1, 8'h80, 1'b0};

    #2;
    applyReset("reset");
    foreach (vecs[i])
      applyStimulus(vecs[i].tag, vecs[i].instr, vecs[i].jmp, vecs[i].rd, vecs[i].alu,
                    vecs[i].ovf, 8'h00, 0, vecs[i].expVal, vecs[i].expBr);

    applyStimulus("ldbAck3", 9'h100, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5E, 3, 8'h5E, 1'b0);
    applyStimulus("ldbAck1", 9'h11F, 8'h00, 8'h00, 8'h00, 1'b0, 8'hC3, 1, 8'hC3, 1'b0);
    applyStimulus("stbAck2", 9'h120, 8'h00, 8'h00, 8'h00, 1'b0, 8'h99, 2, 8'h00, 1'b0);

    // Reset while a load is pending: outputs clear immediately.
    Instruction = 9'h100;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    #1 checkOutput("ldbPending", mkExp(1, 0, 0, 0, 0, 0, 8'h00));
    Reset_n = 1'b0;
    expOvf = 1'b0;
    expMemErr = 1'b0;
    expHalted = 1'b0;
    #1 checkOutput("resetMidMem", mkExp(0, 0, 0, 0, 0, 0, 8'h00));
    @(negedge Clk);
    Reset_n = 1'b1;
    applyStimulus("movAfterReset", 9'h0F3, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 0, 8'h13, 1'b0);

    applyStimulus("stbTimeout", 9'h120, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 0, 8'h00, 1'b0);
    applyReset("resetAfterTimeout");
    applyStimulus("stbAckLast", 9'h120, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, TIMEOUT_C + 1, 8'h00, 1'b0);
    applyStimulus("movNoErr", 9'h0E1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 0, 8'h01, 1'b0);
    applyStimulus("haltOp", 9'h1E0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 0, 8'h00, 1'b0);

    applyReset("resetRandom");
    for (int n = 0; n < 60; n++) begin
      rInstr = 9'($urandom);
      if (rInstr[8:5] == 4'b1111) rInstr[8:5] = 4'b0111;
      sel = $urandom_range(0, 2);
      rJmp = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h00 : 8'($urandom);
      rRd  = 8'($urandom);
      rAlu = 8'($urandom);
      rMem = 8'($urandom);
      rOvf = 1'($urandom);
      rAck = $urandom_range(1, TIMEOUT_C + 1);
      applyStimulus("random", rInstr, rJmp, rRd, rAlu, rOvf, rMem, rAck,
                    refWb(rInstr, rRd, rAlu, rMem), rJmp == 8'h01);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Multi-cycle control sequencer for the 9-bit-instruction core. It replaces the purely combinational decoder with a registered fetch/execute/memory state machine. It also adds a parametrised datapath width, a memory request/acknowledge handshake with timeout, nibble-merge immediate loads, a store opcode, halt, and sticky status flags. It sits between the instruction ROM/fetch unit, the register file, the ALU and data memory, and it owns PC advance, branch resolution and register write-back.

## Interface
Parameters:
- IW, 9, instruction width; opcode = Instruction[IW-1:IW-4], operand = Instruction[IW-5:0]
- DW, 8, data width; must equal 2*(IW-5)
- TIMEOUT, 15, max cycles waiting for MemAck (1..255)

Ports:
- Clk  in  1  clock, rising edge
- Reset_n  in  1  reset, asynchronous, active-low
- Instruction  in  IW  machine code from instruction ROM, sampled in S_FETCH
- jmpReg  in  DW  branch-condition register value
- RdValue  in  DW  current value of destination register
- ALU_out  in  DW  ALU result
- OverFlow  in  1  ALU overflow
- MemReadValue  in  DW  data memory read data, valid with MemAck
- MemAck  in  1  memory transfer complete
- MemReq  out  1  memory request (registered)
- MemWe  out  1  1 = store, 0 = load; valid while MemReq=1
- PcEn  out  1  one-cycle pulse: advance PC / take branch
- Jump  out  1  current instruction is a jump; valid with PcEn
- BranchEn  out  1  jump taken; valid with PcEn
- RegWriteEn  out  1  write RegWriteValue to destination this cycle
- RegWriteValue  out  DW  write-back data
- Halted  out  1  sequencer in S_HALT
- OvfFlag  out  1  sticky: any r-type executed with OverFlow=1
- MemErr  out  1  sticky: memory timeout occurred

## Operation
- Opcodes: 1000 ldb, 1001 stb, 1010 ldh, 1011 ldl, 0111 mov, 1100 jump, 1111 halt, others r-type.
- States: S_FETCH, S_EXEC, S_MEM, S_HALT. Reset state is S_FETCH.
- S_FETCH: IR <= Instruction; go to S_EXEC.
- S_EXEC, decoded from IR:
  - r-type: RegWriteEn=1, value ALU_out; OvfFlag set if OverFlow.
  - mov: RegWriteEn=1, value zero-extended operand.
  - ldh: value {IR[IW-5:1], RdValue[DW/2-1:0]}.
  - ldl: value {RdValue[DW-1:DW/2], IR[IW-5:1]}.
  - jump: Jump=1; BranchEn=1 iff jmpReg == 1 (full-width compare).
  - All of the above pulse PcEn and go to S_FETCH.
  - ldb/stb: MemReq<=1, MemWe<=(stb), go to S_MEM; no PcEn.
  - halt: go to S_HALT; no PcEn.
- S_MEM: hold MemReq/MemWe, increment wait counter.
  - MemAck=1: MemReq<=0, PcEn=1, RegWriteEn=1 with value MemReadValue (ldb only); go to S_FETCH.
  - Counter reaches TIMEOUT with no ack: set MemErr, MemReq<=0, go to S_HALT.
  - MemAck and timeout in the same cycle: ack wins, no error.
- S_HALT: terminal; all pulses 0, Halted=1; exits only on reset.
- MemAck outside S_MEM is ignored.
- Outputs other than MemReq/MemWe are combinational from state, IR and the current inputs. They are 0 in every state/opcode not listed.
- Every RegWriteValue assignment is exactly DW bits wide; there is no sign extension anywhere.

## Timing
- Reset (async assert, any state): state=S_FETCH; IR, wait counter, MemReq, MemWe, OvfFlag and MemErr all 0; every output reads 0.
- Non-memory instruction: 2 cycles (FETCH, EXEC); PcEn is high in the EXEC cycle.
- ldb/stb: 2 + N cycles, where N = cycles from MemReq rising to MemAck inclusive (N>=1). PcEn and write-back occur in the ack cycle.
- MemReq rises on the clock edge leaving S_EXEC. It falls on the edge after ack or timeout.
- Wait counter resets on entry to S_MEM. Timeout is declared in the cycle where the count equals TIMEOUT, i.e. TIMEOUT+1 cycles after MemReq rises.
- Reset deasserted mid-transfer: MemReq is already 0 and the next instruction fetch restarts; memory must abandon the pending request.

## Structure
- Shared package ctrl_pkg: opcode localparams (OP_LDB, OP_STB, OP_LDH, OP_LDL, OP_MOV, OP_JMP, OP_HALT), state encoding, and the DW==2*(IW-5) check.
- One natural sub-module: ctrl_wb_mux, a combinational write-back value selector (opcode, IR operand, RdValue, ALU_out, MemReadValue -> RegWriteValue). The FSM, counter and flags stay in ctrl_seq.

## Test plan
- Reset mid-S_MEM with MemReq=1 -> all outputs 0 immediately; after release the first fetch occurs on the next edge.
- mov 0x13 (Instruction=9'b0111_10011) -> EXEC cycle: RegWriteEn=1, RegWriteValue=0x13, PcEn=1.
- ldh then ldl:
  - ldh imm 0xA with RdValue=0x35 -> RegWriteValue=0xA5.
  - ldl imm 0xC with RdValue=0xA5 -> RegWriteValue=0xAC.
- jump:
  - jmpReg=1 -> Jump=1, BranchEn=1.
  - jmpReg=0x81 -> Jump=1, BranchEn=0.
- ldb with MemAck after 3 cycles and MemReadValue=0x5E -> MemReq high for 3 cycles, MemWe=0; ack cycle has RegWriteEn=1, value 0x5E, PcEn=1; total 5 cycles.
- stb with no MemAck, TIMEOUT=15 -> MemErr=1 and Halted=1 after 16 S_MEM cycles, PcEn never pulses. Repeat with MemAck on cycle 16 -> MemErr stays 0.
